// File: rtl/sio_pkg.sv
// Shared definitions for the SIO UART: FSM state encoding, STATUS bit
// positions and the default bit period.
package sio_pkg;

   localparam int CLKS_PER_BIT_DEF = 16;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_DATA  = 2'd2,
      ST_STOP  = 2'd3
   } sio_state_e;

   localparam int STAT_TX_BUSY   = 0;
   localparam int STAT_RX_VALID  = 1;
   localparam int STAT_OVERRUN   = 2;
   localparam int STAT_FRAME_ERR = 3;

endpackage

// File: rtl/sio_rx.sv
// SIO receiver: synchronizes RXD, mid-bit samples an 8N1 frame and reports
// a one-cycle completion (good stop bit) or framing-error pulse.
module sio_rx
   import sio_pkg::*;
#(
   parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
)
(
   input  logic       CLK,
   input  logic       nRESET,
   input  logic       RXD,
   output logic       rx_done,
   output logic       rx_ferr,
   output logic [7:0] rx_byte
);

   localparam int             CW       = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0]  CNT_LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0]  CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);

   sio_state_e    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    bit_q, bit_d;
   logic [7:0]    shreg_q, shreg_d;
   logic          sync1_q, sync1_d;
   logic          sync2_q, sync2_d;
   logic          prev_q, prev_d;

   assign rx_byte = shreg_q;

   // State register; synchronizer and edge-detect flops reset to the idle level.
   always_ff @(posedge CLK) begin
      if (!nRESET) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         shreg_q <= '0;
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         prev_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         shreg_q <= shreg_d;
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         prev_q  <= prev_d;
      end
   end

   // Next-state logic; only the synchronized line (sync2_q) is ever sampled.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      bit_d   = bit_q;
      shreg_d = shreg_q;
      sync1_d = RXD;
      sync2_d = sync1_q;
      prev_d  = sync2_q;
      rx_done = 1'b0;
      rx_ferr = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            // A falling edge is required, so a line stuck low after a
            // framing error cannot start a new frame.
            if (prev_q && !sync2_q) begin
               cnt_d   = '0;
               state_d = ST_START;
            end
         end
         ST_START: begin
            if (cnt_q == CNT_HALF) begin
               cnt_d = '0;
               if (sync2_q) begin
                  state_d = ST_IDLE;
               end else begin
                  bit_d   = '0;
                  state_d = ST_DATA;
               end
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         ST_DATA: begin
            if (cnt_q == CNT_LAST) begin
               cnt_d   = '0;
               shreg_d = {sync2_q, shreg_q[7:1]};
               bit_d   = bit_q + 3'd1;
               if (bit_q == 3'd7) state_d = ST_STOP;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         ST_STOP: begin
            if (cnt_q == CNT_LAST) begin
               cnt_d   = '0;
               rx_done = sync2_q;
               rx_ferr = !sync2_q;
               state_d = ST_IDLE;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

endmodule

// File: rtl/sio_tx.sv
// SIO transmitter: 8N1, LSB first, one byte per WR strobe while idle.
module sio_tx
   import sio_pkg::*;
#(
   parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
)
(
   input  logic       CLK,
   input  logic       nRESET,
   input  logic       WR,
   input  logic [7:0] WR_DATA,
   output logic       TXD,
   output logic       tx_busy
);

   localparam int             CW       = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0]  CNT_LAST = CW'(CLKS_PER_BIT - 1);

   sio_state_e    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    bit_q, bit_d;
   logic [7:0]    shreg_q, shreg_d;
   logic          txd_q, txd_d;

   assign TXD     = txd_q;
   assign tx_busy = (state_q != ST_IDLE);

   // State register; reset forces the line idle and aborts any frame.
   always_ff @(posedge CLK) begin
      if (!nRESET) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         shreg_q <= '0;
         txd_q   <= 1'b1;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         shreg_q <= shreg_d;
         txd_q   <= txd_d;
      end
   end

   // Next-state logic; TXD is registered so it changes exactly on bit boundaries.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      bit_d   = bit_q;
      shreg_d = shreg_q;
      txd_d   = txd_q;
      if (state_q == ST_IDLE) begin
         txd_d = 1'b1;
         if (WR) begin
            shreg_d = WR_DATA;
            cnt_d   = '0;
            bit_d   = '0;
            txd_d   = 1'b0;
            state_d = ST_START;
         end
      end else if (cnt_q != CNT_LAST) begin
         cnt_d = cnt_q + CW'(1);
      end else begin
         cnt_d = '0;
         unique case (state_q)
            ST_START: begin
               txd_d   = shreg_q[0];
               bit_d   = '0;
               state_d = ST_DATA;
            end
            ST_DATA: begin
               if (bit_q == 3'd7) begin
                  txd_d   = 1'b1;
                  state_d = ST_STOP;
               end else begin
                  shreg_d = {1'b0, shreg_q[7:1]};
                  txd_d   = shreg_q[1];
                  bit_d   = bit_q + 3'd1;
               end
            end
            ST_STOP: begin
               txd_d   = 1'b1;
               state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

endmodule

// File: rtl/sio_uart.sv
// SIO UART top: independent TX and RX engines plus the CPU-visible receive
// buffer and STATUS flags.
module sio_uart
   import sio_pkg::*;
#(
   parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
)
(
   input  logic       CLK,
   input  logic       nRESET,
   input  logic       WR,
   input  logic [7:0] WR_DATA,
   input  logic       RD,
   input  logic       RXD,
   output logic       TXD,
   output logic [7:0] RX_DATA,
   output logic [7:0] STATUS
);

   logic       tx_busy;
   logic       rx_done;
   logic       rx_ferr;
   logic [7:0] rx_byte;

   logic [7:0] rx_data_q, rx_data_d;
   logic       rx_valid_q, rx_valid_d;
   logic       overrun_q, overrun_d;
   logic       frame_err_q, frame_err_d;

   sio_tx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx (
      .CLK     (CLK),
      .nRESET  (nRESET),
      .WR      (WR),
      .WR_DATA (WR_DATA),
      .TXD     (TXD),
      .tx_busy (tx_busy)
   );

   sio_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
      .CLK     (CLK),
      .nRESET  (nRESET),
      .RXD     (RXD),
      .rx_done (rx_done),
      .rx_ferr (rx_ferr),
      .rx_byte (rx_byte)
   );

   assign RX_DATA = rx_data_q;

   // STATUS composition from the live TX state and the sticky RX flags.
   always_comb begin
      STATUS                 = 8'h00;
      STATUS[STAT_TX_BUSY]   = tx_busy;
      STATUS[STAT_RX_VALID]  = rx_valid_q;
      STATUS[STAT_OVERRUN]   = overrun_q;
      STATUS[STAT_FRAME_ERR] = frame_err_q;
   end

   // Receive buffer and flag registers.
   always_ff @(posedge CLK) begin
      if (!nRESET) begin
         rx_data_q   <= 8'h00;
         rx_valid_q  <= 1'b0;
         overrun_q   <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         rx_data_q   <= rx_data_d;
         rx_valid_q  <= rx_valid_d;
         overrun_q   <= overrun_d;
         frame_err_q <= frame_err_d;
      end
   end

   // RD clears first, then any event this cycle sets its flag so a set wins.
   // A byte completing while RD acknowledges the old one replaces it cleanly.
   always_comb begin
      rx_data_d   = rx_data_q;
      rx_valid_d  = rx_valid_q;
      overrun_d   = overrun_q;
      frame_err_d = frame_err_q;
      if (RD) begin
         rx_valid_d  = 1'b0;
         overrun_d   = 1'b0;
         frame_err_d = 1'b0;
      end
      if (rx_done) begin
         if (!rx_valid_q || RD) begin
            rx_data_d  = rx_byte;
            rx_valid_d = 1'b1;
         end else begin
            overrun_d = 1'b1;
         end
      end
      if (rx_ferr) frame_err_d = 1'b1;
   end

endmodule

// File: tb/tb_sio_uart.sv
// Directed bench for sio_uart with a 4-clock bit period.
module tb_sio_uart;

   localparam int CPB = 4;

   logic       CLK     = 1'b0;
   logic       nRESET  = 1'b0;
   logic       WR      = 1'b0;
   logic [7:0] WR_DATA = 8'h00;
   logic       RD      = 1'b0;
   logic       RXD     = 1'b1;
   logic       TXD;
   logic [7:0] RX_DATA;
   logic [7:0] STATUS;

   int n_chk  = 0;
   int n_fail = 0;

   typedef struct {
      logic [7:0] data;
      int         wr2_cycle;
      logic [9:0] exp_frame;
   } tx_vec_t;

   typedef struct {
      logic [7:0] data;
      logic       stop;
      logic       rd_at_stop;
      logic       rd_after;
      logic [7:0] exp_rx;
      logic [7:0] exp_st;
      logic [7:0] exp_st_rd;
   } rx_vec_t;

   tx_vec_t tx_tab [3];
   rx_vec_t rx_tab [7];

   sio_uart #(.CLKS_PER_BIT(CPB)) dut (
      .CLK     (CLK),
      .nRESET  (nRESET),
      .WR      (WR),
      .WR_DATA (WR_DATA),
      .RD      (RD),
      .RXD     (RXD),
      .TXD     (TXD),
      .RX_DATA (RX_DATA),
      .STATUS  (STATUS)
   );

   always #5 CLK = ~CLK;

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // One full TX frame, checked cycle by cycle; optional second WR mid-frame.
   task automatic run_tx(input int idx, input tx_vec_t v);
      WR_DATA = v.data;
      WR      = 1'b1;
      tick();
      WR      = 1'b0;
      for (int c = 0; c < 10 * CPB; c++) begin
         chk($sformatf("tx%0d txd c%0d", idx, c), {15'd0, TXD}, {15'd0, v.exp_frame[c / CPB]});
         chk($sformatf("tx%0d busy c%0d", idx, c), {15'd0, STATUS[0]}, 16'd1);
         if (c == v.wr2_cycle) begin
            WR      = 1'b1;
            WR_DATA = 8'h3C;
         end
         tick();
         WR = 1'b0;
      end
      chk($sformatf("tx%0d busy end", idx), {8'd0, STATUS}, 16'h0000);
      chk($sformatf("tx%0d txd idle", idx), {15'd0, TXD}, 16'd1);
   endtask

   // Drive one RX frame; optionally raise RD on the stop-sample edge.
   task automatic send_rx(input logic [7:0] data, input logic stop, input logic rd_at_stop);
      RXD = 1'b0;
      repeat (CPB) tick();
      for (int i = 0; i < 8; i++) begin
         RXD = data[i];
         repeat (CPB) tick();
      end
      RXD = stop;
      repeat (CPB) tick();
      RXD = 1'b1;
      RD  = rd_at_stop;
      tick();
      RD  = 1'b0;
      tick();
   endtask

   initial begin
      tx_tab[0] = '{8'hA5, -1, 10'b1_1010_0101_0};
      tx_tab[1] = '{8'hA5, 10, 10'b1_1010_0101_0};
      tx_tab[2] = '{8'h3C, -1, 10'b1_0011_1100_0};

      rx_tab[0] = '{8'h5A, 1'b1, 1'b0, 1'b1, 8'h5A, 8'h02, 8'h00};
      rx_tab[1] = '{8'h11, 1'b1, 1'b0, 1'b0, 8'h11, 8'h02, 8'h00};
      rx_tab[2] = '{8'h22, 1'b1, 1'b0, 1'b0, 8'h11, 8'h06, 8'h00};
      rx_tab[3] = '{8'h33, 1'b1, 1'b1, 1'b0, 8'h33, 8'h02, 8'h00};
      rx_tab[4] = '{8'h44, 1'b1, 1'b0, 1'b1, 8'h33, 8'h06, 8'h00};
      rx_tab[5] = '{8'hFF, 1'b0, 1'b0, 1'b1, 8'h33, 8'h08, 8'h00};
      rx_tab[6] = '{8'h81, 1'b1, 1'b0, 1'b0, 8'h81, 8'h02, 8'h00};

      // Reset state
      nRESET = 1'b0;
      repeat (3) tick();
      chk("rst txd", {15'd0, TXD}, 16'd1);
      chk("rst status", {8'd0, STATUS}, 16'h0000);
      chk("rst rx_data", {8'd0, RX_DATA}, 16'h0000);
      nRESET = 1'b1;
      tick();

      // RD with nothing pending changes nothing
      RD = 1'b1;
      tick();
      RD = 1'b0;
      chk("idle rd status", {8'd0, STATUS}, 16'h0000);

      // Transmit table
      for (int i = 0; i < 3; i++) begin
         run_tx(i, tx_tab[i]);
         repeat (3) tick();
      end

      // Receive table
      for (int i = 0; i < 7; i++) begin
         send_rx(rx_tab[i].data, rx_tab[i].stop, rx_tab[i].rd_at_stop);
         chk($sformatf("rx%0d rx_data", i), {8'd0, RX_DATA}, {8'd0, rx_tab[i].exp_rx});
         chk($sformatf("rx%0d status", i), {8'd0, STATUS}, {8'd0, rx_tab[i].exp_st});
         if (rx_tab[i].rd_after) begin
            RD = 1'b1;
            tick();
            RD = 1'b0;
            chk($sformatf("rx%0d status after rd", i), {8'd0, STATUS}, {8'd0, rx_tab[i].exp_st_rd});
         end
         repeat (2) tick();
      end

      // One-cycle low glitch on RXD must not start a frame
      RXD = 1'b0;
      tick();
      RXD = 1'b1;
      repeat (50) tick();
      chk("glitch status", {8'd0, STATUS}, 16'h0002);
      chk("glitch rx_data", {8'd0, RX_DATA}, 16'h0081);

      // Reset in the middle of TX bit 3 and an RX frame
      WR_DATA = 8'hA5;
      WR      = 1'b1;
      RXD     = 1'b0;
      tick();
      WR      = 1'b0;
      repeat (17) tick();
      chk("pre-reset txd", {15'd0, TXD}, 16'd0);
      chk("pre-reset status", {8'd0, STATUS}, 16'h0003);
      nRESET = 1'b0;
      tick();
      chk("mid reset txd", {15'd0, TXD}, 16'd1);
      chk("mid reset status", {8'd0, STATUS}, 16'h0000);
      chk("mid reset rx_data", {8'd0, RX_DATA}, 16'h0000);
      nRESET = 1'b1;
      RXD    = 1'b1;
      repeat (50) tick();
      chk("post reset txd", {15'd0, TXD}, 16'd1);
      chk("post reset status", {8'd0, STATUS}, 16'h0000);
      chk("post reset rx_data", {8'd0, RX_DATA}, 16'h0000);

      // Receive still works after the abort
      send_rx(8'hC3, 1'b1, 1'b0);
      chk("post reset frame rx_data", {8'd0, RX_DATA}, 16'h00C3);
      chk("post reset frame status", {8'd0, STATUS}, 16'h0002);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/sio_uart.md
SIO_UART -- requirements
Module: sio_uart

Interface
REQ-001 Parameter CLKS_PER_BIT, default 16, CLK cycles per serial bit time; legal range 4..255, even values only.
REQ-002 CLK  input  1  system clock; all state changes on rising edge.
REQ-003 nRESET  input  1  reset, synchronous, active-low.
REQ-004 WR  input  1  one-cycle strobe from the CPU SIO register write; loads WR_DATA for transmit.
REQ-005 WR_DATA  input  8  byte to transmit, sampled only when WR=1.
REQ-006 RD  input  1  one-cycle acknowledge; CPU has consumed RX_DATA.
REQ-007 RXD  input  1  asynchronous serial input, idle high.
REQ-008 TXD  output  1  serial output, 8N1, LSB first, idle high.
REQ-009 RX_DATA  output  8  last accepted received byte.
REQ-010 STATUS  output  8  bit0 TX_BUSY, bit1 RX_VALID, bit2 OVERRUN, bit3 FRAME_ERR, bits7:4 = 0.

Function
REQ-011 TX FSM states: IDLE, START, DATA, STOP; each state except IDLE lasts CLKS_PER_BIT cycles per bit.
REQ-012 WR=1 in IDLE: latch WR_DATA, enter START next edge; TXD=0 from the cycle after the WR edge; TX_BUSY=1 in the same cycle.
REQ-013 DATA state drives bits 0..7 in order, 3-bit bit counter, each bit held CLKS_PER_BIT cycles.
REQ-014 STOP drives TXD=1 for CLKS_PER_BIT cycles, then returns to IDLE; TX_BUSY=0 in the first IDLE cycle.
REQ-015 WR while TX_BUSY=1 is ignored; the frame in flight is unaffected and no flag is set.
REQ-016 RXD passes through a 2-flop synchronizer before any use; RX decisions use the synchronized value.
REQ-017 RX FSM states: IDLE, START, DATA, STOP.
REQ-018 IDLE->START on synchronized falling edge (1 then 0).
REQ-019 START samples at CLKS_PER_BIT/2 cycles: if 1, treat as glitch and return to IDLE with no flag change; if 0, enter DATA.
REQ-020 DATA samples each bit CLKS_PER_BIT cycles after the previous sample; bits shift in LSB first.
REQ-021 STOP sample=1, RX_VALID=0: load RX_DATA, set RX_VALID.
REQ-022 STOP sample=1, RX_VALID=1, RD=0 same cycle: discard byte, keep RX_DATA, set OVERRUN.
REQ-023 STOP sample=1, RD=1 same cycle: load RX_DATA, RX_VALID stays 1, no OVERRUN.
REQ-024 STOP sample=0: discard byte, set FRAME_ERR, return to IDLE; a new frame then requires RXD to return high first.
REQ-025 RD=1 clears RX_VALID, OVERRUN and FRAME_ERR; a set event in the same cycle wins over the clear.
REQ-026 RD while RX_VALID=0 has no effect beyond REQ-025.
REQ-027 TX and RX are fully independent; simultaneous WR, RD and RX completion are each handled per the rules above.
REQ-028 Baud counters are per-direction, width ceil(log2(CLKS_PER_BIT)) bits, reload at 0 with no wrap-around drift.

Reset
REQ-029 nRESET=0 at a rising edge: TXD=1, both FSMs IDLE, counters 0, RX_DATA=8'h00, STATUS=8'h00, synchronizer flops=1.
REQ-030 Reset mid-frame aborts the frame immediately; TXD=1 on the next cycle; no partial byte is stored.

Structure
REQ-031 Shared package sio_pkg holds the tx/rx state enum, STATUS bit-index constants and the default CLKS_PER_BIT.
REQ-032 RX and TX are separate sub-modules, sio_rx and sio_tx, instantiated by sio_uart; status logic lives in sio_uart.

Verification (CLKS_PER_BIT=4)
REQ-033 WR with WR_DATA=8'hA5 in IDLE -> TXD = 0,1,0,1,0,0,1,0,1,1 (start, LSB first, stop), each held 4 cycles; TX_BUSY=1 for 40 cycles.
REQ-034 Second WR with 8'h3C during the 8'hA5 frame -> only 8'hA5 transmitted; TX_BUSY drops after 40 cycles.
REQ-035 Drive RXD frame 8'h5A -> RX_DATA=8'h5A, STATUS=8'h02; RD pulse -> STATUS=8'h00.
REQ-036 Frames 8'h11 then 8'h22 with no RD -> RX_DATA=8'h11, STATUS=8'h06; frame 8'h33 with RD pulsed on the stop-sample cycle -> RX_DATA=8'h33, OVERRUN not set.
REQ-037 RXD low for 1 cycle only -> no state change; frame 8'hFF with stop bit 0 -> STATUS bit3=1, RX_VALID=0.
REQ-038 nRESET low at bit 3 of TX 8'hA5 and mid RX frame -> TXD=1 next cycle, STATUS=8'h00, RX_DATA=8'h00.
